// File: rtl/io_bridge_pkg.sv
// rtl/io_bridge_pkg.sv - shared constants and seven-segment encoding for io_bridge
package io_bridge_pkg;

    localparam logic [19:0] IO_BASE_HI = 20'hFFFFF;

    localparam logic [11:0] DIG_OFF = 12'h000;
    localparam logic [11:0] CNT_OFF = 12'h020;
    localparam logic [11:0] LED_OFF = 12'h060;
    localparam logic [11:0] SW_OFF  = 12'h070;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {DP,G,F,E,D,C,B,A}; DP held off in every code.
    function automatic logic [7:0] hex7seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0:    seg = 8'hC0;
            4'h1:    seg = 8'hF9;
            4'h2:    seg = 8'hA4;
            4'h3:    seg = 8'hB0;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h92;
            4'h6:    seg = 8'h82;
            4'h7:    seg = 8'hF8;
            4'h8:    seg = 8'h80;
            4'h9:    seg = 8'h90;
            4'hA:    seg = 8'h88;
            4'hB:    seg = 8'h83;
            4'hC:    seg = 8'hC6;
            4'hD:    seg = 8'hA1;
            4'hE:    seg = 8'h86;
            4'hF:    seg = 8'h8E;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/io_bridge_seg7_scan.sv
// rtl/io_bridge_seg7_scan.sv - free-running 8-digit seven-segment scan engine
module seg7_scan
    import io_bridge_pkg::*;
#(
    parameter int SCAN_DIV = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] digit_i,
    output logic [7:0]  dig_en_o,
    output logic [7:0]  seg_o
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    dig_en_q, dig_en_d;
    logic [7:0]    seg_q, seg_d;
    logic          wrap;

    always_comb begin
        wrap       = (scan_cnt_q == CW'(SCAN_DIV - 1));
        scan_cnt_d = wrap ? '0 : scan_cnt_q + CW'(1);
        idx_d      = wrap ? idx_q + 3'd1 : idx_q;
        // Both outputs derive from the next index so they flip on the same edge.
        dig_en_d   = ~(8'h01 << idx_d);
        seg_d      = hex7seg(digit_i[{idx_d, 2'b00} +: 4]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
            idx_q      <= '0;
            dig_en_q   <= 8'hFE;
            seg_q      <= 8'hC0;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            dig_en_q   <= dig_en_d;
            seg_q      <= seg_d;
        end
    end

    assign dig_en_o = dig_en_q;
    assign seg_o    = seg_q;

endmodule

// File: rtl/io_bridge.sv
// rtl/io_bridge.sv - data RAM / memory-mapped I/O bridge; IO_CYCLE_COUNTER_EN adds a cycle counter
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int DRAM_AW  = 14,
    parameter int SCAN_DIV = 20000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        wdata_i,
    input  logic               we_i,
    output logic [31:0]        rdata_o,
    output logic [DRAM_AW-1:0] dram_addr_o,
    output logic [31:0]        dram_wdata_o,
    output logic               dram_we_o,
    input  logic [31:0]        dram_rdata_i,
    input  logic [23:0]        sw_i,
    output logic [23:0]        led_o,
    output logic [7:0]         dig_en_o,
    output logic [7:0]         seg_o
);

    logic        io_sel;
    logic [9:0]  word_off;
    logic        dig_we, led_we, cnt_we;
    logic [31:0] dig_q, dig_d;
    logic [23:0] led_q, led_d;
    logic [23:0] sw_meta_q, sw_meta_d;
    logic [23:0] sw_sync_q, sw_sync_d;
    logic [31:0] cnt_val;
    logic [31:0] io_rdata;
    logic        unused_byte_sel;

    assign io_sel          = (addr_i[31:12] == IO_BASE_HI);
    assign word_off        = addr_i[11:2];
    assign unused_byte_sel = ^addr_i[1:0];

    assign dram_addr_o  = addr_i[DRAM_AW+1:2];
    assign dram_wdata_o = wdata_i;
    assign dram_we_o    = we_i & ~io_sel;

    assign dig_we = we_i & io_sel & (word_off == DIG_OFF[11:2]);
    assign led_we = we_i & io_sel & (word_off == LED_OFF[11:2]);
    assign cnt_we = we_i & io_sel & (word_off == CNT_OFF[11:2]);

    always_comb begin
        dig_d     = dig_we ? wdata_i : dig_q;
        led_d     = led_we ? wdata_i[23:0] : led_q;
        sw_meta_d = sw_i;
        sw_sync_d = sw_meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_q     <= '0;
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            dig_q     <= dig_d;
            led_q     <= led_d;
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
        end
    end

`ifdef IO_CYCLE_COUNTER_EN
    logic [31:0] cnt_q, cnt_d;

    // A software load wins over the free-running increment.
    always_comb begin
        cnt_d = cnt_we ? wdata_i : cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_val = cnt_q;
`else
    logic unused_cnt_we;
    assign unused_cnt_we = cnt_we;
    assign cnt_val       = '0;
`endif

    always_comb begin
        io_rdata = '0;
        case (word_off)
            DIG_OFF[11:2]: io_rdata = dig_q;
            CNT_OFF[11:2]: io_rdata = cnt_val;
            LED_OFF[11:2]: io_rdata = {8'h00, led_q};
            SW_OFF[11:2]:  io_rdata = {8'h00, sw_sync_q};
            default:       io_rdata = '0;
        endcase
    end

    assign rdata_o = io_sel ? io_rdata : dram_rdata_i;
    assign led_o   = led_q;

    seg7_scan #(
        .SCAN_DIV(SCAN_DIV)
    ) u_scan (
        .clk     (clk),
        .rst_n   (rst_n),
        .digit_i (dig_q),
        .dig_en_o(dig_en_o),
        .seg_o   (seg_o)
    );

endmodule
